// File: rtl/cva6_lsu_arb_pkg.sv
// ----------------------------------------------------------------------------
// cva6_lsu_arb_pkg
// Shared types for the LSU memory-port arbiter:
//   state_e  - arbiter FSM state (IDLE / REQ / RESP)
//   owner_e  - which requester owns the memory port (LOAD / STORE)
//   TIMEOUT_DEFAULT - default response watchdog limit in cycles
// ----------------------------------------------------------------------------
package cva6_lsu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LOAD  = 1'b0,
    OWN_STORE = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/cva6_lsu_mem_arb_if.sv
// ----------------------------------------------------------------------------
// cva6_lsu_mem_arb_if
// Bundles the load port, store port and memory port of the LSU arbiter.
//
// Handshake rules (all signals sampled on the rising clock edge):
//   - A requester raises *_req_i with a stable *_addr_i and holds both until
//     it sees *_gnt_o. *_gnt_o is a one-cycle pulse; the request is accepted
//     in the cycle where req and gnt are both high. Dropping a request before
//     its grant simply withdraws it.
//   - *_resp_o is a one-cycle pulse returned only to the requester that owns
//     the single outstanding transaction.
//   - mem_req_o stays high with constant mem_addr_o / mem_we_o until
//     mem_gnt_i; mem_rvalid_i is a one-cycle response pulse and is only
//     meaningful after the memory granted the request.
//
// Modports:
//   slave  - the arbiter (takes requests, drives memory port)
//   master - the environment (load unit, store buffer, memory model)
// ----------------------------------------------------------------------------
interface cva6_lsu_mem_arb_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              ld_req_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_gnt_o;
  logic              ld_resp_o;

  logic              st_req_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic              st_gnt_o;
  logic              st_resp_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;

  logic              err_o;

  modport slave (
    input  ld_req_i, ld_addr_i, st_req_i, st_addr_i, mem_gnt_i, mem_rvalid_i,
    output ld_gnt_o, ld_resp_o, st_gnt_o, st_resp_o,
    output mem_req_o, mem_we_o, mem_addr_o, err_o
  );

  modport master (
    output ld_req_i, ld_addr_i, st_req_i, st_addr_i, mem_gnt_i, mem_rvalid_i,
    input  ld_gnt_o, ld_resp_o, st_gnt_o, st_resp_o,
    input  mem_req_o, mem_we_o, mem_addr_o, err_o
  );

endinterface

// File: rtl/cva6_lsu_rr_arb.sv
// ----------------------------------------------------------------------------
// cva6_lsu_rr_arb
// Two-way load/store picker with a word-address match override.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   ld_req_i       - load requesting
//   st_req_i       - store requesting
//   ld_word_i      - load word address (byte address without bits [1:0])
//   st_word_i      - store word address
//   grant_i        - the pick is being granted this cycle (updates history)
//   valid_o        - at least one requester present
//   pick_o         - winner of this cycle
// ----------------------------------------------------------------------------
module cva6_lsu_rr_arb
  import cva6_lsu_arb_pkg::*;
#(
  parameter int unsigned WORD_W = 30
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_req_i,
  input  logic              st_req_i,
  input  logic [WORD_W-1:0] ld_word_i,
  input  logic [WORD_W-1:0] st_word_i,
  input  logic              grant_i,
  output logic              valid_o,
  output owner_e            pick_o
);

  owner_e last_owner_q;

  assign valid_o = ld_req_i | st_req_i;

  always_comb begin
    pick_o = OWN_LOAD;
    if (ld_req_i && st_req_i) begin
      // A store to the same word must drain before the load reads it,
      // otherwise the load would observe stale data.
      if (ld_word_i == st_word_i) begin
        pick_o = OWN_STORE;
      end else begin
        pick_o = (last_owner_q == OWN_STORE) ? OWN_LOAD : OWN_STORE;
      end
    end else if (st_req_i) begin
      pick_o = OWN_STORE;
    end
  end

  // Reset to STORE so that the first contention favours the load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_owner_q <= OWN_STORE;
    end else if (grant_i) begin
      last_owner_q <= pick_o;
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_arb.sv
// ----------------------------------------------------------------------------
// cva6_lsu_mem_arb
// Arbitrates the single data-memory port between the load unit and the
// store-buffer drain, with exactly one transaction outstanding.
//   clk_i        - clock, all state on the rising edge
//   rst_ni       - asynchronous active-low reset
//   bus          - load / store / memory port bundle (slave modport)
//   dbg_state_o  - current FSM state, for observation only
//
// Optional feature: define CVA6_LSU_ARB_TIMEOUT_EN to enable a response
// watchdog. After TIMEOUT cycles in RESP without mem_rvalid_i the owner's
// resp is pulsed together with err_o and the port returns to IDLE. Without
// the macro err_o is tied low and RESP waits indefinitely.
// ----------------------------------------------------------------------------
module cva6_lsu_mem_arb
  import cva6_lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cva6_lsu_mem_arb_if.slave   bus,
  output state_e              dbg_state_o
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;

  logic   arb_valid;
  owner_e arb_pick;
  logic   grant;
  logic   resp;
  logic   err;
  logic   mem_req;

  cva6_lsu_rr_arb #(
    .WORD_W (WORD_W)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ld_req_i  (bus.ld_req_i),
    .st_req_i  (bus.st_req_i),
    .ld_word_i (bus.ld_addr_i[ADDR_W-1:2]),
    .st_word_i (bus.st_addr_i[ADDR_W-1:2]),
    .grant_i   (grant),
    .valid_o   (arb_valid),
    .pick_o    (arb_pick)
  );

`ifdef CVA6_LSU_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  // Held at zero while waiting for mem_gnt_i, so it starts from zero on the
  // first RESP cycle and counts every RESP cycle without a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (state_q == ST_REQ) begin
      wd_q <= '0;
    end else if (state_q == ST_RESP && !bus.mem_rvalid_i) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    resp    = 1'b0;
    err     = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_ni so no grant leaks out while reset is held.
        if (arb_valid && rst_ni) begin
          grant   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        // A response in the grant cycle belongs to nobody and is dropped.
        if (bus.mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid_i) begin
          resp    = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef CVA6_LSU_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          resp    = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_LOAD;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= arb_pick;
        addr_q  <= (arb_pick == OWN_STORE) ? bus.st_addr_i : bus.ld_addr_i;
      end
    end
  end

  assign bus.ld_gnt_o   = grant & (arb_pick == OWN_LOAD);
  assign bus.st_gnt_o   = grant & (arb_pick == OWN_STORE);
  assign bus.ld_resp_o  = resp & (owner_q == OWN_LOAD);
  assign bus.st_resp_o  = resp & (owner_q == OWN_STORE);
  assign bus.mem_req_o  = mem_req;
  assign bus.mem_we_o   = mem_req & (owner_q == OWN_STORE);
  assign bus.mem_addr_o = addr_q;
  assign bus.err_o      = err;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/cva6_lsu_mem_arb.md
CVA6_LSU_MEM_ARB -- requirements
Module: cva6_lsu_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter TIMEOUT, default 15, response watchdog limit in cycles; used only when CVA6_LSU_ARB_TIMEOUT_EN is defined.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 ld_req_i  in  1  load unit requests the port; held until ld_gnt_o.
REQ-006 ld_addr_i  in  ADDR_W  load address; stable while ld_req_i is high.
REQ-007 ld_gnt_o  out  1  one-cycle pulse: load accepted.
REQ-008 ld_resp_o  out  1  one-cycle pulse: load data returned.
REQ-009 st_req_i  in  1  committed store at store-buffer head requests drain; held until st_gnt_o.
REQ-010 st_addr_i  in  ADDR_W  store address; stable while st_req_i is high.
REQ-011 st_gnt_o  out  1  one-cycle pulse: store accepted.
REQ-012 st_resp_o  out  1  one-cycle pulse: store write acknowledged.
REQ-013 mem_req_o  out  1  memory request valid.
REQ-014 mem_we_o  out  1  1 = store, 0 = load; valid with mem_req_o.
REQ-015 mem_addr_o  out  ADDR_W  registered address of the owning requester.
REQ-016 mem_gnt_i  in  1  memory accepted the request.
REQ-017 mem_rvalid_i  in  1  memory response, one cycle.
REQ-018 err_o  out  1  one-cycle pulse: response timeout.

Function
REQ-019 FSM states: IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-020 In IDLE, with any request present, the arbiter:
- picks a winner;
- pulses the winner's gnt that cycle;
- registers owner, address and mem_we;
- moves to REQ.
REQ-021 Both requesting, word addresses (addr[ADDR_W-1:2]) equal -> store wins (RAW ordering); otherwise round-robin on last_owner.
REQ-022 last_owner updates on every grant; after reset it equals STORE, so the first contention goes to the load.
REQ-023 REQ: mem_req_o=1 and mem_addr_o/mem_we_o held constant; on mem_gnt_i -> RESP next cycle.
REQ-024 mem_rvalid_i is ignored outside RESP, including the same cycle as mem_gnt_i.
REQ-025 RESP: on mem_rvalid_i, the owner's resp pulses combinationally that cycle -> IDLE next cycle.
REQ-026 Minimum grant-to-resp latency: 2 cycles; no new grant until IDLE, so back-to-back grants are at least 3 cycles apart.
REQ-027 ld_gnt_o and st_gnt_o are never high in the same cycle; a resp never pulses for a non-owner.
REQ-028 A request dropped before its grant is not an error; no grant is issued for it.

Reset
REQ-029 rst_ni low asynchronously forces:
- IDLE, last_owner=STORE, watchdog=0;
- all outputs 0, mem_addr_o=0.
REQ-030 An in-flight transaction is abandoned on reset; no resp is issued for it after release.

Configuration
REQ-031 With CVA6_LSU_ARB_TIMEOUT_EN defined:
- a counter clears on entering RESP and increments each RESP cycle without mem_rvalid_i;
- reaching TIMEOUT pulses err_o and the owner's resp in the same cycle -> IDLE.
REQ-032 Without the macro: no counter, err_o tied 0, RESP waits indefinitely.

Structure
REQ-033 Package cva6_lsu_arb_pkg holds the FSM state enum, the owner enum (LOAD/STORE) and the TIMEOUT default.
REQ-034 Sub-module cva6_lsu_rr_arb holds the 2-way round-robin with the address-match override (combinational pick plus last_owner register).

Verification
REQ-035 Lone load 0xCAD, mem_gnt_i at +1, mem_rvalid_i at +3 -> ld_gnt_o cycle 0, mem_req_o=1 mem_we_o=0 mem_addr_o=0xCAD, ld_resp_o once, st_* silent.
REQ-036 Load 0x100 and store 0x200 together from reset, each completing -> load granted first, then store; mem_we_o 0 then 1.
REQ-037 Load 0xCAD and store 0xCAC (same word) together -> store granted first regardless of last_owner.
REQ-038 rst_ni low during RESP of a load -> all outputs 0 immediately; a later mem_rvalid_i produces no ld_resp_o.
REQ-039 With the macro, TIMEOUT=15, no mem_rvalid_i -> err_o and st_resp_o pulse 15 cycles after RESP entry, then IDLE; without the macro, stays in RESP.
REQ-040 mem_gnt_i and mem_rvalid_i in the same REQ cycle -> rvalid ignored, RESP entered, resp only on a later rvalid.
